branch_feedback_queue: RTL and testbench

In-order queue of in-flight conditional-branch predictions that closes the loop back into the branch predictor. The fetch stage pushes each predicted branch (PC, predicted direction, alternate PC). Execute resolves entries out of order by tag. The queue retires entries in order from the head, driving the predictor's update port (`instr_addr`, `transition_signal`, `correctness`), and raises a flush with a redirect PC on a misprediction.

---
 rtl/branch_feedback_queue.sv | 173 +++++++++++++++++
 tb/tb_branch_feedback_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_feedback_queue.sv
// rtl/branch_feedback_queue.sv - in-order branch prediction feedback queue driving predictor updates and mispredict flushes
// Optional retirement/miss counters are enabled with BRANCH_FEEDBACK_STATS_EN.
module branch_feedback_queue #(
  parameter int DEPTH_WIDTH = 3,
  parameter int LOCAL_WIDTH = 10
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   push_valid_in,
  input  logic [31:0]            push_pc_in,
  input  logic                   push_pred_in,
  input  logic [31:0]            push_alt_pc_in,
  output logic [DEPTH_WIDTH-1:0] push_tag_out,
  output logic                   full_out,
  output logic                   empty_out,
  input  logic                   resolve_valid_in,
  input  logic [DEPTH_WIDTH-1:0] resolve_tag_in,
  input  logic                   resolve_taken_in,
  input  logic                   flush_in,
  output logic [LOCAL_WIDTH-1:0] instr_addr_out,
  output logic                   transition_signal_out,
  output logic                   correctness_out,
  output logic                   flush_out,
  output logic [31:0]            redirect_pc_out
`ifdef BRANCH_FEEDBACK_STATS_EN
  ,
  output logic [31:0]            branch_cnt_out,
  output logic [31:0]            miss_cnt_out
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_UPDATE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t state_q, state_next;

  logic [DEPTH-1:0]       valid_q, resolved_q, pred_q, taken_q;
  logic [LOCAL_WIDTH-1:0] idx_q    [DEPTH];
  logic [31:0]            alt_pc_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] head_q, tail_q;
  logic [DEPTH_WIDTH:0]   count_q;

  logic head_ready, head_match;
  logic do_load_addr, do_update, do_clear, do_flush_strobe;
  logic push_accept, resolve_accept;
  logic unused_pc_bits;

  // Only the predictor index bits of the PC are ever needed after push.
  assign unused_pc_bits = ^{push_pc_in[31:LOCAL_WIDTH+2], push_pc_in[1:0]};

  assign full_out     = (count_q == FULL_COUNT);
  assign empty_out    = (count_q == '0);
  assign push_tag_out = tail_q;

  assign head_ready = valid_q[head_q] && resolved_q[head_q];
  assign head_match = (pred_q[head_q] == taken_q[head_q]);

  always_comb begin
    state_next      = state_q;
    do_load_addr    = 1'b0;
    do_update       = 1'b0;
    do_clear        = 1'b0;
    do_flush_strobe = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_in) begin
          do_clear = 1'b1;
        end else if (head_ready) begin
          do_load_addr = 1'b1;
          state_next   = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (flush_in) begin
          do_clear   = 1'b1;
          state_next = ST_RUN;
        end else begin
          do_update  = 1'b1;
          state_next = head_match ? ST_RUN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        do_clear        = 1'b1;
        do_flush_strobe = 1'b1;
        state_next      = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    push_accept    = push_valid_in && !full_out && !do_clear;
    resolve_accept = resolve_valid_in && valid_q[resolve_tag_in] && !do_clear;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q               <= ST_RUN;
      valid_q               <= '0;
      resolved_q            <= '0;
      pred_q                <= '0;
      taken_q               <= '0;
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      instr_addr_out        <= '0;
      transition_signal_out <= 1'b0;
      correctness_out       <= 1'b0;
      flush_out             <= 1'b0;
      redirect_pc_out       <= '0;
    end else if (rdy_in) begin
      state_q               <= state_next;
      transition_signal_out <= do_update;
      flush_out             <= do_flush_strobe;
      if (do_load_addr) instr_addr_out <= idx_q[head_q];
      if (do_update) begin
        correctness_out <= head_match;
        if (!head_match) redirect_pc_out <= alt_pc_q[head_q];
      end
      if (do_clear) begin
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (resolve_accept) begin
          resolved_q[resolve_tag_in] <= 1'b1;
          taken_q[resolve_tag_in]    <= resolve_taken_in;
        end
        if (do_update) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (push_accept) begin
          valid_q[tail_q]    <= 1'b1;
          resolved_q[tail_q] <= 1'b0;
          pred_q[tail_q]     <= push_pred_in;
          tail_q             <= tail_q + 1'b1;
        end
        case ({push_accept, do_update})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload storage needs no reset; valid bits gate every read.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && push_accept) begin
      idx_q[tail_q]    <= push_pc_in[LOCAL_WIDTH+1:2];
      alt_pc_q[tail_q] <= push_alt_pc_in;
    end
  end

`ifdef BRANCH_FEEDBACK_STATS_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      branch_cnt_out <= '0;
      miss_cnt_out   <= '0;
    end else if (rdy_in && do_update) begin
      branch_cnt_out <= branch_cnt_out + 32'd1;
      if (!head_match) miss_cnt_out <= miss_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_feedback_queue.sv
// tb/tb_branch_feedback_queue.sv - directed self-checking bench for branch_feedback_queue
module tb_branch_feedback_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        push_valid_in;
  logic [31:0] push_pc_in;
  logic        push_pred_in;
  logic [31:0] push_alt_pc_in;
  logic [2:0]  push_tag_out;
  logic        full_out;
  logic        empty_out;
  logic        resolve_valid_in;
  logic [2:0]  resolve_tag_in;
  logic        resolve_taken_in;
  logic        flush_in;
  logic [9:0]  instr_addr_out;
  logic        transition_signal_out;
  logic        correctness_out;
  logic        flush_out;
  logic [31:0] redirect_pc_out;
`ifdef BRANCH_FEEDBACK_STATS_EN
  logic [31:0] branch_cnt_out;
  logic [31:0] miss_cnt_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  branch_feedback_queue dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .push_valid_in         (push_valid_in),
    .push_pc_in            (push_pc_in),
    .push_pred_in          (push_pred_in),
    .push_alt_pc_in        (push_alt_pc_in),
    .push_tag_out          (push_tag_out),
    .full_out              (full_out),
    .empty_out             (empty_out),
    .resolve_valid_in      (resolve_valid_in),
    .resolve_tag_in        (resolve_tag_in),
    .resolve_taken_in      (resolve_taken_in),
    .flush_in              (flush_in),
    .instr_addr_out        (instr_addr_out),
    .transition_signal_out (transition_signal_out),
    .correctness_out       (correctness_out),
    .flush_out             (flush_out),
    .redirect_pc_out       (redirect_pc_out)
`ifdef BRANCH_FEEDBACK_STATS_EN
    ,
    .branch_cnt_out        (branch_cnt_out),
    .miss_cnt_out          (miss_cnt_out)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    push_valid_in    = 1'b0;
    push_pc_in       = '0;
    push_pred_in     = 1'b0;
    push_alt_pc_in   = '0;
    resolve_valid_in = 1'b0;
    resolve_tag_in   = '0;
    resolve_taken_in = 1'b0;
    flush_in         = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic pred, input logic [31:0] alt);
    push_valid_in  = 1'b1;
    push_pc_in     = pc;
    push_pred_in   = pred;
    push_alt_pc_in = alt;
    tick();
    push_valid_in  = 1'b0;
  endtask

  task automatic resolve_one(input logic [2:0] tag, input logic taken);
    resolve_valid_in = 1'b1;
    resolve_tag_in   = tag;
    resolve_taken_in = taken;
    tick();
    resolve_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b0;
    tick();
    tick();
    checks++;
    if (empty_out !== 1'b1 || full_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b required empty=1 full=0", empty_out, full_out);
    end
    checks++;
    if (transition_signal_out !== 1'b0 || flush_out !== 1'b0 || correctness_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: trans=%b flush=%b corr=%b required 0 0 0",
               transition_signal_out, flush_out, correctness_out);
    end
    checks++;
    if (instr_addr_out !== 10'h0 || redirect_pc_out !== 32'h0 || push_tag_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: addr=%h redirect=%h tag=%0d required 0 0 0",
               instr_addr_out, redirect_pc_out, push_tag_out);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_single_retire();
    do_reset();
    checks++;
    if (push_tag_out !== 3'd0) begin
      errors++;
      $display("FAIL single_tag: tag=%0d required 0", push_tag_out);
    end
    push_one(32'h0000_1abc, 1'b1, 32'h0000_1ac0);
    checks++;
    if (empty_out !== 1'b0) begin
      errors++;
      $display("FAIL single_not_empty: empty=%b required 0", empty_out);
    end
    resolve_one(3'd0, 1'b1);
    tick();
    checks++;
    if (instr_addr_out !== 10'h2af || transition_signal_out !== 1'b0) begin
      errors++;
      $display("FAIL single_addr: addr=%h trans=%b required addr=2af trans=0",
               instr_addr_out, transition_signal_out);
    end
    tick();
    checks++;
    if (transition_signal_out !== 1'b1 || correctness_out !== 1'b1 || flush_out !== 1'b0 || empty_out !== 1'b1) begin
      errors++;
      $display("FAIL single_update: trans=%b corr=%b flush=%b empty=%b required 1 1 0 1",
               transition_signal_out, correctness_out, flush_out, empty_out);
    end
    tick();
    checks++;
    if (transition_signal_out !== 1'b0 || flush_out !== 1'b0 || instr_addr_out !== 10'h2af) begin
      errors++;
      $display("FAIL single_after: trans=%b flush=%b addr=%h required 0 0 2af",
               transition_signal_out, flush_out, instr_addr_out);
    end
  endtask

  task automatic test_out_of_order_mispredict();
    int strobes;
    do_reset();
    push_one(32'h0000_0040, 1'b1, 32'h1111_0000);
    checks++;
    if (push_tag_out !== 3'd1) begin
      errors++;
      $display("FAIL ooo_tag1: tag=%0d required 1", push_tag_out);
    end
    push_one(32'h0000_0080, 1'b0, 32'h2222_0000);
    resolve_one(3'd1, 1'b1);
    checks++;
    if (transition_signal_out !== 1'b0 || instr_addr_out !== 10'h0) begin
      errors++;
      $display("FAIL ooo_no_early_retire: trans=%b addr=%h required 0 000", transition_signal_out, instr_addr_out);
    end
    resolve_one(3'd0, 1'b0);
    tick();
    checks++;
    if (instr_addr_out !== 10'h010) begin
      errors++;
      $display("FAIL ooo_addr: addr=%h required 010", instr_addr_out);
    end
    tick();
    checks++;
    if (transition_signal_out !== 1'b1 || correctness_out !== 1'b0 || flush_out !== 1'b0 ||
        redirect_pc_out !== 32'h1111_0000) begin
      errors++;
      $display("FAIL ooo_update: trans=%b corr=%b flush=%b redirect=%h required 1 0 0 11110000",
               transition_signal_out, correctness_out, flush_out, redirect_pc_out);
    end
    tick();
    checks++;
    if (flush_out !== 1'b1 || transition_signal_out !== 1'b0 || redirect_pc_out !== 32'h1111_0000 ||
        empty_out !== 1'b1 || push_tag_out !== 3'd0) begin
      errors++;
      $display("FAIL ooo_flush: flush=%b trans=%b redirect=%h empty=%b tag=%0d required 1 0 11110000 1 0",
               flush_out, transition_signal_out, redirect_pc_out, empty_out, push_tag_out);
    end
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (transition_signal_out === 1'b1 || flush_out === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL ooo_tag1_silent: strobes=%0d required 0", strobes);
    end
  endtask

  task automatic test_full_wrap();
    int bad_tags;
    do_reset();
    bad_tags = 0;
    for (int i = 0; i < 8; i++) begin
      if (push_tag_out !== 3'(i)) bad_tags++;
      push_one(32'h0000_0100 + 32'(i * 4), 1'b1, 32'h0000_9000);
    end
    checks++;
    if (bad_tags != 0 || full_out !== 1'b1) begin
      errors++;
      $display("FAIL full_fill: bad_tags=%0d full=%b required 0 1", bad_tags, full_out);
    end
    push_one(32'h0000_0999, 1'b1, 32'h0000_9000);
    checks++;
    if (full_out !== 1'b1 || push_tag_out !== 3'd0 || empty_out !== 1'b0) begin
      errors++;
      $display("FAIL full_drop: full=%b tag=%0d empty=%b required 1 0 0", full_out, push_tag_out, empty_out);
    end
    resolve_one(3'd0, 1'b1);
    tick();
    push_valid_in  = 1'b1;
    push_pc_in     = 32'h0000_0aa0;
    push_pred_in   = 1'b0;
    push_alt_pc_in = 32'h0000_0bb0;
    tick();
    checks++;
    if (transition_signal_out !== 1'b1 || full_out !== 1'b0 || push_tag_out !== 3'd0) begin
      errors++;
      $display("FAIL full_pop_no_reuse: trans=%b full=%b tag=%0d required 1 0 0",
               transition_signal_out, full_out, push_tag_out);
    end
    tick();
    push_valid_in = 1'b0;
    checks++;
    if (full_out !== 1'b1 || push_tag_out !== 3'd1) begin
      errors++;
      $display("FAIL full_wrap_push: full=%b tag=%0d required 1 1", full_out, push_tag_out);
    end
  endtask

  task automatic test_flush_in();
    do_reset();
    push_one(32'h0000_0100, 1'b1, 32'h7777_0000);
    resolve_one(3'd0, 1'b0);
    tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    checks++;
    if (transition_signal_out !== 1'b0 || flush_out !== 1'b0 || empty_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_update: trans=%b flush=%b empty=%b required 0 0 1",
               transition_signal_out, flush_out, empty_out);
    end
    tick();
    checks++;
    if (transition_signal_out !== 1'b0 || flush_out !== 1'b0 || push_tag_out !== 3'd0 || redirect_pc_out !== 32'h0) begin
      errors++;
      $display("FAIL flush_in_after: trans=%b flush=%b tag=%0d redirect=%h required 0 0 0 0",
               transition_signal_out, flush_out, push_tag_out, redirect_pc_out);
    end
  endtask

  task automatic test_rdy_stall();
    int early;
    do_reset();
    push_one(32'h0000_0f00, 1'b0, 32'h5555_0000);
    resolve_one(3'd0, 1'b0);
    tick();
    rdy_in = 1'b0;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (transition_signal_out !== 1'b0 || empty_out !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL rdy_hold_update: bad_cycles=%0d required 0", early);
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (transition_signal_out !== 1'b1 || correctness_out !== 1'b1 || empty_out !== 1'b1 || instr_addr_out !== 10'h3c0) begin
      errors++;
      $display("FAIL rdy_release: trans=%b corr=%b empty=%b addr=%h required 1 1 1 3c0",
               transition_signal_out, correctness_out, empty_out, instr_addr_out);
    end
    rdy_in = 1'b0;
    tick();
    checks++;
    if (transition_signal_out !== 1'b1) begin
      errors++;
      $display("FAIL rdy_strobe_held: trans=%b required 1", transition_signal_out);
    end
    rdy_in = 1'b1;
    tick();
    tick();
    checks++;
    if (transition_signal_out !== 1'b0 || flush_out !== 1'b0) begin
      errors++;
      $display("FAIL rdy_once: trans=%b flush=%b required 0 0", transition_signal_out, flush_out);
    end
  endtask

  task automatic test_back_to_back();
    int strobes;
    int last_cycle;
    int bad_gap;
    logic [9:0] addrs [3];
    do_reset();
    push_one(32'h0000_0010, 1'b1, 32'h0);
    push_one(32'h0000_0020, 1'b1, 32'h0);
    push_one(32'h0000_0030, 1'b1, 32'h0);
    resolve_valid_in = 1'b1;
    resolve_taken_in = 1'b1;
    strobes    = 0;
    last_cycle = -1;
    bad_gap    = 0;
    for (int c = 0; c < 12; c++) begin
      resolve_tag_in = 3'(c);
      if (c == 3) resolve_valid_in = 1'b0;
      tick();
      if (transition_signal_out === 1'b1) begin
        if (strobes < 3) addrs[strobes] = instr_addr_out;
        if (last_cycle >= 0 && c - last_cycle != 2) bad_gap++;
        last_cycle = c;
        strobes++;
      end
    end
    checks++;
    if (strobes != 3 || bad_gap != 0) begin
      errors++;
      $display("FAIL b2b_count: strobes=%0d bad_gaps=%0d required 3 0", strobes, bad_gap);
    end
    checks++;
    if (strobes == 3 && (addrs[0] !== 10'h004 || addrs[1] !== 10'h008 || addrs[2] !== 10'h00c)) begin
      errors++;
      $display("FAIL b2b_order: addrs=%h %h %h required 004 008 00c", addrs[0], addrs[1], addrs[2]);
    end
    checks++;
    if (empty_out !== 1'b1 || flush_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: empty=%b flush=%b required 1 0", empty_out, flush_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_retire();
    test_out_of_order_mispredict();
    test_full_wrap();
    test_flush_in();
    test_rdy_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
